// File: rtl/avg_threshold_detector_if.sv
// Bus between the moving-average filter (master) and the threshold detector (slave).
//   average/average_valid : averaged sample stream and its qualifier
//   hi_thresh/lo_thresh   : arm / disarm thresholds
//   clear                 : sync clear of peak/trough/event_count
//   alarm, alarm_rise, alarm_fall, peak, trough, event_count : detector status
interface avg_threshold_detector_if #(
  parameter int unsigned N     = 16,
  parameter int unsigned CNT_W = 8
);
  logic [N-1:0]     average;
  logic             average_valid;
  logic [N-1:0]     hi_thresh;
  logic [N-1:0]     lo_thresh;
  logic             clear;
  logic             alarm;
  logic             alarm_rise;
  logic             alarm_fall;
  logic [N-1:0]     peak;
  logic [N-1:0]     trough;
  logic [CNT_W-1:0] event_count;

  modport master (
    output average, average_valid, hi_thresh, lo_thresh, clear,
    input  alarm, alarm_rise, alarm_fall, peak, trough, event_count
  );

  modport slave (
    input  average, average_valid, hi_thresh, lo_thresh, clear,
    output alarm, alarm_rise, alarm_fall, peak, trough, event_count
  );
endinterface

// File: rtl/avg_threshold_detector.sv
// Debounced hysteretic alarm on the moving-average stream, with peak/trough
// tracking and a saturating alarm-event counter. Never backpressures.
//   clk : posedge clock
//   rst : asynchronous active-high reset
//   bus : avg_threshold_detector_if slave (stream/thresholds in, status out)
module avg_threshold_detector #(
  parameter int unsigned N        = 16,
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  avg_threshold_detector_if.slave bus
);

  localparam int unsigned DCNT_W = 8;

  typedef enum logic [1:0] {S_LOW, S_ARM, S_HIGH, S_DISARM} state_t;

  state_t             state_q, state_d;
  logic [DCNT_W-1:0]  dcnt_q, dcnt_d, dcnt_inc;
  logic               hi_qual, lo_qual, deb_done;
  logic               alarm_d, rise_d, fall_d;
  logic [N-1:0]       peak_d, trough_d;
  logic [CNT_W-1:0]   evc_d;

  // Next-state: debounce counter only advances on valid samples
  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    hi_qual  = (bus.average >= bus.hi_thresh);
    lo_qual  = (bus.average <= bus.lo_thresh);
    dcnt_inc = dcnt_q + DCNT_W'(1);
    deb_done = (dcnt_inc == DCNT_W'(DEBOUNCE));
    if (bus.average_valid) begin
      unique case (state_q)
        S_LOW, S_ARM: begin
          if (!hi_qual) begin
            state_d = S_LOW;
            dcnt_d  = '0;
          end else if (deb_done) begin
            state_d = S_HIGH;
            dcnt_d  = '0;
          end else begin
            state_d = S_ARM;
            dcnt_d  = dcnt_inc;
          end
        end
        S_HIGH, S_DISARM: begin
          if (!lo_qual) begin
            state_d = S_HIGH;
            dcnt_d  = '0;
          end else if (deb_done) begin
            state_d = S_LOW;
            dcnt_d  = '0;
          end else begin
            state_d = S_DISARM;
            dcnt_d  = dcnt_inc;
          end
        end
        default: begin
          state_d = S_LOW;
          dcnt_d  = '0;
        end
      endcase
    end
    alarm_d = (state_d == S_HIGH) || (state_d == S_DISARM);
    rise_d  = alarm_d & ~bus.alarm;
    fall_d  = ~alarm_d & bus.alarm;
  end

  // Status next-values; reset values 0/'1 double as identities for max/min,
  // so the first sample after reset or clear loads both trackers.
  always_comb begin
    peak_d   = bus.clear ? '0 : bus.peak;
    trough_d = bus.clear ? '1 : bus.trough;
    evc_d    = bus.clear ? '0 : bus.event_count;
    if (bus.average_valid) begin
      if (bus.average > peak_d)   peak_d   = bus.average;
      if (bus.average < trough_d) trough_d = bus.average;
    end
    if (rise_d && (evc_d != '1)) evc_d = evc_d + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_LOW;
      dcnt_q          <= '0;
      bus.alarm       <= 1'b0;
      bus.alarm_rise  <= 1'b0;
      bus.alarm_fall  <= 1'b0;
      bus.peak        <= '0;
      bus.trough      <= '1;
      bus.event_count <= '0;
    end else begin
      state_q         <= state_d;
      dcnt_q          <= dcnt_d;
      bus.alarm       <= alarm_d;
      bus.alarm_rise  <= rise_d;
      bus.alarm_fall  <= fall_d;
      bus.peak        <= peak_d;
      bus.trough      <= trough_d;
      bus.event_count <= evc_d;
    end
  end

endmodule
